// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
//
// Moore controller that holds one 16-bit instruction and steps the datapath
// control strobes through the cycles needed to execute it. One instruction
// runs per start pulse; w is high while the controller is idle.
//
// Instruction layout: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd,
//                     [4:3] sh, [2:0] Rm, [7:0] imm8
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   load         capture `in` into the instruction register (idle only)
//   s            start executing the held instruction (idle only)
//   in[15:0]     instruction word
//   w            idle / ready
//   illegal      sticky undefined-instruction flag (trap build only)
//   write, vsel, loada, loadb, asel, bsel, loadc, loads   datapath strobes
//   readnum[2:0], writenum[2:0]   register file indices
//   ALUop[1:0], shift[1:0]        ALU operation and shifter control
//   datapath_in[15:0]             sign-extended imm8 of the held instruction
//
// Build option:
//   DATAPATH_SEQ_ILLEGAL_TRAP_EN  when defined, an undefined instruction sets
//                                 `illegal`, which blocks further starts until
//                                 reset. When undefined, such instructions are
//                                 silent no-ops and `illegal` is tied low.
// ---------------------------------------------------------------------------
module datapath_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        s,
   input  logic [15:0] in,
   output logic        w,
   output logic        illegal,
   output logic        write,
   output logic        vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic        loadc,
   output logic        loads,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [1:0]  ALUop,
   output logic [1:0]  shift,
   output logic [15:0] datapath_in
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG
   } state_t;

   typedef enum logic [2:0] {
      I_MOV_IMM, I_MOV_REG, I_ADD, I_CMP, I_AND, I_MVN, I_UNDEF
   } instr_t;

   // Classify from {opcode, op}.
   function automatic instr_t classify(input logic [4:0] opc_op);
      case (opc_op)
         5'b110_10: classify = I_MOV_IMM;
         5'b110_00: classify = I_MOV_REG;
         5'b101_00: classify = I_ADD;
         5'b101_01: classify = I_CMP;
         5'b101_10: classify = I_AND;
         5'b101_11: classify = I_MVN;
         default:   classify = I_UNDEF;
      endcase
   endfunction

   state_t      state_reg, state_next;
   logic [15:0] ir_reg, ir_next;
   instr_t      cls_reg, cls_next;
   logic        trap_hold;

   logic        w_next, write_next, vsel_next, loada_next, loadb_next;
   logic        asel_next, bsel_next, loadc_next, loads_next;
   logic [2:0]  readnum_next, writenum_next;
   logic [1:0]  aluop_next, shift_next;

   assign cls_reg     = classify(ir_reg[15:11]);
   assign cls_next    = classify(ir_next[15:11]);
   assign datapath_in = {{8{ir_reg[7]}}, ir_reg[7:0]};

   // Next state and instruction register.
   always_comb begin
      state_next = state_reg;
      ir_next    = ir_reg;
      case (state_reg)
         S_WAIT: begin
            if (load)
               ir_next = in;
            if (s && !trap_hold)
               state_next = S_DECODE;
         end
         S_DECODE: begin
            case (cls_reg)
               I_MOV_IMM:           state_next = S_WIMM;
               I_MOV_REG, I_MVN:    state_next = S_GETB;
               I_ADD, I_CMP, I_AND: state_next = S_GETA;
               default:             state_next = S_WAIT;
            endcase
         end
         S_WIMM:  state_next = S_WAIT;
         S_GETA:  state_next = S_GETB;
         S_GETB:  state_next = S_EXEC;
         S_EXEC:  state_next = (cls_reg == I_CMP) ? S_WAIT : S_WREG;
         S_WREG:  state_next = S_WAIT;
         default: state_next = S_WAIT;
      endcase
   end

   // Outputs are decoded for the state being entered so that the registered
   // strobes line up exactly with the state they belong to.
   always_comb begin
      w_next        = 1'b0;
      write_next    = 1'b0;
      vsel_next     = 1'b0;
      loada_next    = 1'b0;
      loadb_next    = 1'b0;
      asel_next     = 1'b0;
      bsel_next     = 1'b0;
      loadc_next    = 1'b0;
      loads_next    = 1'b0;
      readnum_next  = 3'd0;
      writenum_next = 3'd0;
      aluop_next    = 2'b00;
      shift_next    = 2'b00;
      case (state_next)
         S_WAIT: w_next = 1'b1;
         S_WIMM: begin
            vsel_next     = 1'b1;
            write_next    = 1'b1;
            writenum_next = ir_next[10:8];
         end
         S_GETA: begin
            readnum_next = ir_next[10:8];
            loada_next   = 1'b1;
         end
         S_GETB: begin
            readnum_next = ir_next[2:0];
            loadb_next   = 1'b1;
         end
         S_EXEC: begin
            shift_next = ir_next[4:3];
            // Single-operand forms force the A operand to zero.
            asel_next  = (cls_next == I_MOV_REG) || (cls_next == I_MVN);
            aluop_next = (cls_next == I_MOV_REG) ? 2'b00 : ir_next[12:11];
            loads_next = 1'b1;
            loadc_next = (cls_next != I_CMP);
         end
         S_WREG: begin
            write_next    = 1'b1;
            writenum_next = ir_next[7:5];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_WAIT;
         ir_reg    <= 16'h0000;
         w         <= 1'b1;
         write     <= 1'b0;
         vsel      <= 1'b0;
         loada     <= 1'b0;
         loadb     <= 1'b0;
         asel      <= 1'b0;
         bsel      <= 1'b0;
         loadc     <= 1'b0;
         loads     <= 1'b0;
         readnum   <= 3'd0;
         writenum  <= 3'd0;
         ALUop     <= 2'b00;
         shift     <= 2'b00;
      end else begin
         state_reg <= state_next;
         ir_reg    <= ir_next;
         w         <= w_next;
         write     <= write_next;
         vsel      <= vsel_next;
         loada     <= loada_next;
         loadb     <= loadb_next;
         asel      <= asel_next;
         bsel      <= bsel_next;
         loadc     <= loadc_next;
         loads     <= loads_next;
         readnum   <= readnum_next;
         writenum  <= writenum_next;
         ALUop     <= aluop_next;
         shift     <= shift_next;
      end
   end

`ifdef DATAPATH_SEQ_ILLEGAL_TRAP_EN
   logic illegal_reg;
   logic illegal_set;

   // Raised on the edge that leaves DECODE with an undefined instruction.
   assign illegal_set = (state_reg == S_DECODE) && (cls_reg == I_UNDEF);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         illegal_reg <= 1'b0;
      else if (illegal_set)
         illegal_reg <= 1'b1;
   end

   assign trap_hold = illegal_reg;
   assign illegal   = illegal_reg;
`else
   assign trap_hold = 1'b0;
   assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// ---------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Directed bench for datapath_sequencer. A per-instruction cycle script,
// built from the instruction class and timing table, gives the strobes
// expected after every clock edge; one compare process checks them. A small
// register-file/ALU model driven by the DUT strobes gives the architectural
// results, which are pinned with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_datapath_sequencer;

   logic        clk;
   logic        rst;
   logic        load;
   logic        s;
   logic [15:0] in_word;
   logic        w, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads;
   logic [2:0]  readnum, writenum;
   logic [1:0]  ALUop, shift;
   logic [15:0] datapath_in;

   datapath_sequencer dut (
      .clk         (clk),
      .reset       (rst),
      .load        (load),
      .s           (s),
      .in          (in_word),
      .w           (w),
      .illegal     (illegal),
      .write       (write),
      .vsel        (vsel),
      .loada       (loada),
      .loadb       (loadb),
      .asel        (asel),
      .bsel        (bsel),
      .loadc       (loadc),
      .loads       (loads),
      .readnum     (readnum),
      .writenum    (writenum),
      .ALUop       (ALUop),
      .shift       (shift),
      .datapath_in (datapath_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // ---------------- cycle script model ----------------
   localparam int K_DEC  = 0;
   localparam int K_WIMM = 1;
   localparam int K_GETA = 2;
   localparam int K_GETB = 3;
   localparam int K_EXEC = 4;
   localparam int K_WREG = 5;
   localparam int K_IDLE = 6;
   localparam int K_TRAP = 7;   // idle, and the sticky flag is now set

   int          exp_q[$];
   logic [15:0] exp_ir      = 16'h0000;
   logic        exp_illegal = 1'b0;
   bit          checking    = 1'b0;

   // {w,write,vsel,loada,loadb,asel,bsel,loadc,loads,readnum,writenum,ALUop,shift}
   logic [18:0] dut_vec;
   assign dut_vec = {w, write, vsel, loada, loadb, asel, bsel, loadc, loads,
                     readnum, writenum, ALUop, shift};

   function automatic logic [18:0] exp_vec(input int k, input logic [15:0] ir);
      logic e_w, e_wr, e_vs, e_la, e_lb, e_as, e_bs, e_lc, e_ls;
      logic [2:0] e_rn, e_wn;
      logic [1:0] e_op, e_sh;
      logic is_movr, is_mvn, is_cmp;
      {e_w, e_wr, e_vs, e_la, e_lb, e_as, e_bs, e_lc, e_ls} = 9'b0;
      e_rn = 3'd0; e_wn = 3'd0; e_op = 2'd0; e_sh = 2'd0;
      is_movr = (ir[15:11] == 5'b11000);
      is_mvn  = (ir[15:11] == 5'b10111);
      is_cmp  = (ir[15:11] == 5'b10101);
      case (k)
         K_IDLE, K_TRAP: e_w = 1'b1;
         K_WIMM: begin e_vs = 1'b1; e_wr = 1'b1; e_wn = ir[10:8]; end
         K_GETA: begin e_rn = ir[10:8]; e_la = 1'b1; end
         K_GETB: begin e_rn = ir[2:0];  e_lb = 1'b1; end
         K_EXEC: begin
            e_sh = ir[4:3];
            e_as = is_movr | is_mvn;
            e_op = is_movr ? 2'b00 : ir[12:11];
            e_ls = 1'b1;
            e_lc = !is_cmp;
         end
         K_WREG: begin e_wr = 1'b1; e_wn = ir[7:5]; end
         default: ;
      endcase
      return {e_w, e_wr, e_vs, e_la, e_lb, e_as, e_bs, e_lc, e_ls, e_rn, e_wn, e_op, e_sh};
   endfunction

   // Expected state sequence after edges 1..n of one start; idle afterwards.
   task automatic plan(input logic [15:0] ir);
      if (exp_illegal)
         return;
      case (ir[15:11])
         5'b11010: exp_q = {exp_q, K_DEC, K_WIMM};
         5'b11000, 5'b10111: exp_q = {exp_q, K_DEC, K_GETB, K_EXEC, K_WREG};
         5'b10100, 5'b10110: exp_q = {exp_q, K_DEC, K_GETA, K_GETB, K_EXEC, K_WREG};
         5'b10101: exp_q = {exp_q, K_DEC, K_GETA, K_GETB, K_EXEC};
         default: begin
`ifdef DATAPATH_SEQ_ILLEGAL_TRAP_EN
            exp_q = {exp_q, K_DEC, K_TRAP};
`else
            exp_q = {exp_q, K_DEC};
`endif
         end
      endcase
   endtask

   initial begin
      int k;
      forever begin
         @(posedge clk);
         #1;
         if (checking && !rst) begin
            if (exp_q.size() > 0) k = exp_q.pop_front();
            else                  k = K_IDLE;
            if (k == K_TRAP) exp_illegal = 1'b1;
            check("strobes", dut_vec, exp_vec(k, exp_ir));
            check("datapath_in", datapath_in, {{8{exp_ir[7]}}, exp_ir[7:0]});
            check("illegal", illegal, exp_illegal);
         end
      end
   end

   // ---------------- datapath model driven by DUT strobes ----------------
   logic [15:0] rf [8];
   logic [15:0] a_reg, b_reg, c_reg;
   logic        z_reg;
   int          write_cnt = 0;
   int          loada_cnt = 0;
   logic [15:0] b_shifted, alu_out, a_in, b_in;

   always_comb begin
      case (shift)
         2'b00:   b_shifted = b_reg;
         2'b01:   b_shifted = b_reg << 1;
         2'b10:   b_shifted = b_reg >> 1;
         default: b_shifted = {b_reg[15], b_reg[15:1]};
      endcase
      a_in = asel ? 16'h0000 : a_reg;
      b_in = bsel ? datapath_in : b_shifted;
      case (ALUop)
         2'b00:   alu_out = a_in + b_in;
         2'b01:   alu_out = a_in - b_in;
         2'b10:   alu_out = a_in & b_in;
         default: alu_out = ~b_in;
      endcase
   end

   always @(posedge clk) begin
      if (write) begin
         rf[writenum] <= vsel ? datapath_in : c_reg;
         write_cnt    <= write_cnt + 1;
      end
      if (loada) begin
         a_reg     <= rf[readnum];
         loada_cnt <= loada_cnt + 1;
      end
      if (loadb) b_reg <= rf[readnum];
      if (loadc) c_reg <= alu_out;
      if (loads) z_reg <= (alu_out == 16'h0000);
   end

   // ---------------- drivers ----------------
   task automatic do_load(input logic [15:0] word);
      @(negedge clk);
      load    = 1'b1;
      in_word = word;
      exp_ir  = word;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic start();
      @(negedge clk);
      s = 1'b1;
      plan(exp_ir);
      @(negedge clk);
      s = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wait_done: %0d script steps left, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [15:0] word);
      do_load(word);
      start();
      wait_done();
      $display("instr %h executed (R0=%h R1=%h R2=%h R3=%h R4=%h R7=%h)",
               word, rf[0], rf[1], rf[2], rf[3], rf[4], rf[7]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      exp_ir      = 16'h0000;
      exp_illegal = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int wc0;
      int la0;
      rst = 1'b1; load = 1'b0; s = 1'b0; in_word = 16'h0000;
      repeat (2) @(negedge clk);
      check("reset_strobes", dut_vec, 19'h40000);
      check("reset_dp_in", datapath_in, 16'h0000);
      check("reset_illegal", illegal, 1'b0);
      rst = 1'b0;
      checking = 1'b1;

      // MOV R0,#7 ; MOV R1,#2
      do_load(16'hD007);
      check("dp_in_imm7", datapath_in, 16'h0007);
      start(); wait_done();
      check("R0", rf[0], 16'h0007);
      run(16'hD102);
      check("R1", rf[1], 16'h0002);

      // ADD R2,R1,R0,LSL#1 -> 2 + 14
      run(16'hA148);
      check("R2_add", rf[2], 16'h0010);

      // Reset while the ADD sits in GETB.
      do_load(16'hA148);
      start();                       // edge 1 already passed
      @(posedge clk); @(posedge clk);  // edges 2, 3 -> GETB
      #3;
      rst = 1'b1;
      exp_q.delete();
      exp_ir      = 16'h0000;
      exp_illegal = 1'b0;
      #1;
      check("abort_strobes", dut_vec, 19'h40000);
      check("abort_dp_in", datapath_in, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      $display("reset asserted mid-instruction");
      // IR is now 0, which has no defined encoding.
      start(); wait_done();
      $display("instr 0000 executed after reset");
      do_reset();

      // MOV R3,#-8 ; CMP R3,R3
      do_load(16'hD3F8);
      check("dp_in_neg8", datapath_in, 16'hFFF8);
      start(); wait_done();
      check("R3", rf[3], 16'hFFF8);
      wc0 = write_cnt;
      run(16'hAB03);
      check("cmp_Z", z_reg, 1'b1);
      check("cmp_writes", write_cnt - wc0, 0);
      check("cmp_R3", rf[3], 16'hFFF8);

      // R4 = 0x78 << 1 ; MVN R7,R4
      run(16'hD478);
      run(16'hC08C);
      check("R4", rf[4], 16'h00F0);
      la0 = loada_cnt;
      run(16'hB8E4);
      check("R7_mvn", rf[7], 16'hFF0F);
      check("mvn_loada", loada_cnt - la0, 0);

      // s held high: two back-to-back MOV R5,#0x11 with one idle cycle between.
      do_load(16'hD511);
      @(negedge clk);
      s = 1'b1;
      exp_q = {exp_q, K_DEC, K_WIMM, K_IDLE, K_DEC, K_WIMM};
      repeat (4) @(negedge clk);
      s = 1'b0;
      wait_done();
      check("R5", rf[5], 16'h0011);
      $display("instr d511 executed twice with s held");

      // Undefined word, then another start.
      run(16'hE000);
      wc0 = write_cnt;
      start(); wait_done();
      check("undef_writes", write_cnt - wc0, 0);
`ifdef DATAPATH_SEQ_ILLEGAL_TRAP_EN
      check("illegal_sticky", illegal, 1'b1);
      check("illegal_w", w, 1'b1);
      do_reset();
      check("illegal_cleared", illegal, 1'b0);
`else
      check("illegal_tied", illegal, 1'b0);
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
